// File: rtl/program_loader.sv
// program_loader: receives a boot image over a byte stream and writes it into
// instruction memory while holding the processor core in reset.
//
// Image format: 16-bit word count N (MSB first), then 4N bytes, each word
// little-endian (first byte lands in bits 7:0).
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing byte equal
// to the XOR of all payload bytes; without it the image is accepted as soon as
// the last word is written.
//
// Ports:
//   clk         rising-edge clock shared with the processor
//   reset       synchronous active-high reset
//   rx_data     incoming byte
//   rx_valid    rx_data valid; accepted when rx_valid & rx_ready
//   rx_ready    loader can accept a byte
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address for imem_we
//   imem_wdata  instruction word for imem_we
//   core_reset  reset to the processor core, released only after a good load
//   load_done   image loaded successfully (sticky until reset)
//   load_error  load aborted (sticky until reset)
module program_loader #(
  parameter int unsigned IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_error
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Memory capacity in words; a count above this cannot fit.
  localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_ADDR_W;

  state_t                 r_state;
  logic [7:0]             r_count_hi;
  logic [15:0]            r_count;
  logic [1:0]             r_byte_cnt;
  // One bit wider than the address so a full-capacity image never wraps.
  logic [IMEM_ADDR_W:0]   r_word_idx;
  logic [23:0]            r_word;
  logic                   r_rx_ready;
  logic                   r_imem_we;
  logic [IMEM_ADDR_W-1:0] r_imem_addr;
  logic [31:0]            r_imem_wdata;
  logic                   r_core_reset;
  logic                   r_load_done;
  logic                   r_load_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif

  logic                   w_accept;
  logic [15:0]            w_count;
  logic                   w_last_word;

  assign w_accept    = rx_valid & r_rx_ready;
  assign w_count     = {r_count_hi, rx_data};
  assign w_last_word = (17'(r_word_idx) + 17'd1) == {1'b0, r_count};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= CNT_HI;
      r_count_hi   <= '0;
      r_count      <= '0;
      r_byte_cnt   <= '0;
      r_word_idx   <= '0;
      r_word       <= '0;
      r_rx_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        CNT_HI: begin
          if (w_accept) begin
            r_count_hi <= rx_data;
            r_state    <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (w_accept) begin
            r_count <= w_count;
            if ({1'b0, w_count} > MAX_WORDS) begin
              r_state      <= ERROR;
              r_rx_ready   <= 1'b0;
              r_load_error <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              // r_word holds the first three bytes, oldest in the low byte.
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_word_idx[IMEM_ADDR_W-1:0];
              r_imem_wdata <= {rx_data, r_word};
              r_word_idx   <= r_word_idx + 1'b1;
              r_byte_cnt   <= '0;
              if (w_last_word) begin
                r_state <= CHECK;
              end
            end else begin
              r_word     <= {rx_data, r_word[23:8]};
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state      <= DONE;
              r_core_reset <= 1'b0;
              r_load_done  <= 1'b1;
            end else begin
              r_state      <= ERROR;
              r_load_error <= 1'b1;
            end
          end
`else
          r_state      <= DONE;
          r_rx_ready   <= 1'b0;
          r_core_reset <= 1'b0;
          r_load_done  <= 1'b1;
`endif
        end
        DONE, ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= CNT_HI;
        end
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_reset = r_core_reset;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader with a 4-word memory
// (IMEM_ADDR_W=2) so the capacity boundary is reachable with short images.
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum.
module tb_program_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          load_done;
  logic          load_error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [7:0]  img[$];
  logic [7:0]  tb_csum;

  program_loader #(.IMEM_ADDR_W(AW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Log every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      q_addr.push_back(32'(imem_addr));
      q_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic add_count(input logic [15:0] n);
    img.delete();
    img.push_back(n[15:8]);
    img.push_back(n[7:0]);
    tb_csum = 8'h00;
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      img.push_back(w[8*i +: 8]);
      tb_csum = tb_csum ^ w[8*i +: 8];
    end
  endtask

  // Present one byte; optional idle cycles first carry junk data with
  // rx_valid low, which must not be consumed.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned guard;
    int unsigned idle;
    if (gaps) begin
      idle = $urandom_range(0, 3);
      for (int unsigned k = 0; k < idle; k++) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    guard = 0;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_img(input bit gaps);
    foreach (img[i]) send_byte(img[i], gaps);
  endtask

  task automatic wait_end(input string tag);
    int unsigned guard = 0;
    @(negedge clk);
    while (!(load_done || load_error) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!(load_done || load_error)) check(tag, 32'd0, 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_rx_ready",   32'(rx_ready),   32'd1);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", imem_wdata,      32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_load_done",  32'(load_done),  32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
  endtask

  task automatic check_done();
    check("done_load_done",  32'(load_done),  32'd1);
    check("done_load_error", 32'(load_error), 32'd0);
    check("done_core_reset", 32'(core_reset), 32'd0);
    check("done_rx_ready",   32'(rx_ready),   32'd0);
  endtask

  initial begin
    logic [31:0] w3[3];
    logic [31:0] w4[4];
    w3[0] = 32'hA1B2C3D4; w3[1] = 32'h00FF00FF; w3[2] = 32'hDEADBEEF;
    w4[0] = 32'h01020304; w4[1] = 32'h05060708;
    w4[2] = 32'h090A0B0C; w4[3] = 32'h0D0E0F10;

    // Reset state.
    do_reset();
    check_reset_state();

    // Single word: 00 01 78 56 34 12 [08].
    img.delete();
    img.push_back(8'h00); img.push_back(8'h01);
    img.push_back(8'h78); img.push_back(8'h56);
    img.push_back(8'h34); img.push_back(8'h12);
    send_img(1'b0);
    check("w1_we_next_cycle", 32'(imem_we),   32'd1);
    check("w1_addr_now",      32'(imem_addr), 32'd0);
    check("w1_data_now",      imem_wdata,     32'h12345678);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h08, 1'b0);
`endif
    wait_end("w1_end_timeout");
    check_done();
    check("w1_nwrites", 32'(q_addr.size()), 32'd1);
    if (q_addr.size() == 1) begin
      check("w1_addr", q_addr[0], 32'd0);
      check("w1_data", q_data[0], 32'h12345678);
    end
    // Terminal: further valid bytes are ignored.
    @(negedge clk);
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("term_nwrites", 32'(q_addr.size()), 32'd1);
    check("term_done",    32'(load_done),     32'd1);

    // Reset after a completed load clears outputs.
    do_reset();
    check_reset_state();

    // N = 0.
    add_count(16'd0);
`ifdef LOADER_CHECKSUM_EN
    img.push_back(8'h00);
`endif
    send_img(1'b0);
    wait_end("n0_end_timeout");
    check_done();
    check("n0_nwrites", 32'(q_addr.size()), 32'd0);

    // N = 5 exceeds the 4-word memory.
    do_reset();
    add_count(16'd5);
    send_img(1'b0);
    check("n5_load_error", 32'(load_error), 32'd1);
    check("n5_rx_ready",   32'(rx_ready),   32'd0);
    repeat (3) @(negedge clk);
    check("n5_nwrites",    32'(q_addr.size()), 32'd0);
    check("n5_core_reset", 32'(core_reset),    32'd1);
    check("n5_load_done",  32'(load_done),     32'd0);

    // N = 3 with random rx_valid gaps.
    do_reset();
    add_count(16'd3);
    for (int i = 0; i < 3; i++) add_word(w3[i]);
`ifdef LOADER_CHECKSUM_EN
    img.push_back(tb_csum);
`endif
    send_img(1'b1);
    wait_end("n3_end_timeout");
    check_done();
    check("n3_nwrites", 32'(q_addr.size()), 32'd3);
    if (q_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("n3_addr%0d", i), q_addr[i], 32'(i));
        check($sformatf("n3_data%0d", i), q_data[i], w3[i]);
      end
    end

    // N = 4 fills memory exactly.
    do_reset();
    add_count(16'd4);
    for (int i = 0; i < 4; i++) add_word(w4[i]);
`ifdef LOADER_CHECKSUM_EN
    img.push_back(tb_csum);
`endif
    send_img(1'b0);
    wait_end("n4_end_timeout");
    check_done();
    check("n4_nwrites", 32'(q_addr.size()), 32'd4);
    if (q_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("n4_addr%0d", i), q_addr[i], 32'(i));
        check($sformatf("n4_data%0d", i), q_data[i], w4[i]);
      end
    end

    // Reset mid-word, then a clean single-word image.
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    do_reset();
    check("mid_rx_ready", 32'(rx_ready), 32'd1);
    add_count(16'd1);
    add_word(32'hCAFE1234);
`ifdef LOADER_CHECKSUM_EN
    img.push_back(tb_csum);
`endif
    send_img(1'b0);
    wait_end("mid_end_timeout");
    check_done();
    check("mid_nwrites", 32'(q_addr.size()), 32'd1);
    if (q_addr.size() == 1) begin
      check("mid_addr", q_addr[0], 32'd0);
      check("mid_data", q_data[0], 32'hCAFE1234);
    end

`ifdef LOADER_CHECKSUM_EN
    // Correct payload, wrong checksum.
    do_reset();
    add_count(16'd1);
    add_word(32'h12345678);
    img.push_back(tb_csum ^ 8'h01);
    send_img(1'b0);
    wait_end("bad_end_timeout");
    check("bad_load_error", 32'(load_error), 32'd1);
    check("bad_load_done",  32'(load_done),  32'd0);
    check("bad_core_reset", 32'(core_reset), 32'd1);
    check("bad_rx_ready",   32'(rx_ready),   32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter IMEM_ADDR_W, default 10, meaning instruction-memory word-address width (capacity 2^IMEM_ADDR_W words).
REQ-003 clk  input  1  rising-edge clock, shared with the processor.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 rx_data  input  8  incoming byte.
REQ-006 rx_valid  input  1  rx_data valid; byte accepted on a cycle with rx_valid=1 and rx_ready=1.
REQ-007 rx_ready  output  1  loader can accept a byte.
REQ-008 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 imem_addr  output  IMEM_ADDR_W  word address for imem_we.
REQ-010 imem_wdata  output  32  instruction word for imem_we.
REQ-011 core_reset  output  1  held-high reset to the processor core.
REQ-012 load_done  output  1  image loaded successfully; sticky.
REQ-013 load_error  output  1  load aborted; sticky.

Function
REQ-014 The image format SHALL be: 2-byte word count N (MSB first), then 4N bytes, each word's bytes little-endian (first byte = bits 7:0).
REQ-015 The FSM SHALL have states CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR; reset enters CNT_HI.
REQ-016 CNT_HI -> CNT_LO on an accepted byte; CNT_LO -> DATA on an accepted byte if N>0, else -> CHECK.
REQ-017 In CNT_LO, N > 2^IMEM_ADDR_W SHALL transition to ERROR without any write.
REQ-018 In DATA, a 2-bit byte counter SHALL assemble words; on the 4th accepted byte, imem_we SHALL be 1 in the following cycle with imem_addr = word index (0,1,...,N-1) and the completed word.
REQ-019 After the write of word N-1 is issued, the FSM SHALL be in CHECK (the cycle after the 4th byte of the last word was accepted).
REQ-020 rx_ready SHALL be 1 in CNT_HI, CNT_LO, DATA, CHECK and 0 in DONE and ERROR; bytes with rx_valid=0 SHALL not advance any counter.
REQ-021 CHECK SHALL behave as defined under Configuration and end in DONE or ERROR.
REQ-022 core_reset SHALL be 1 in every state except DONE; load_done=1 only in DONE; load_error=1 only in ERROR.
REQ-023 DONE and ERROR SHALL be terminal until reset; further rx_valid is ignored.
REQ-024 Word index counter SHALL be IMEM_ADDR_W+1 bits wide so N = 2^IMEM_ADDR_W loads fully without wrap-around.

Reset
REQ-025 On reset: state CNT_HI, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_error=0, byte/word counters and checksum cleared.
REQ-026 Reset mid-load SHALL discard any partial word and count; words already written are not erased.

Configuration
REQ-027 With macro LOADER_CHECKSUM_EN defined, CHECK SHALL accept one byte and go to DONE if it equals XOR of all 4N payload bytes, else to ERROR.
REQ-028 Without LOADER_CHECKSUM_EN, CHECK SHALL transition to DONE in one cycle without consuming a byte, and no checksum logic SHALL be present.

Verification
REQ-029 Stream 00 01 78 56 34 12 (+checksum 08 if enabled) -> one imem_we, addr 0, data 0x12345678; then load_done=1, core_reset=0, rx_ready=0.
REQ-030 Stream 00 00 (N=0) -> no imem_we; load_done=1 (with checksum enabled, checksum byte 00 required).
REQ-031 IMEM_ADDR_W=2, N=5 -> load_error=1 after the count low byte, no imem_we, core_reset stays 1.
REQ-032 N=3 with rx_valid toggled randomly -> writes to addr 0,1,2 in order, each exactly once, data matching bytes.
REQ-033 Reset asserted after 2 payload bytes of word 1, then full 1-word image -> word written to addr 0, load_done=1.
REQ-034 LOADER_CHECKSUM_EN defined, correct payload, wrong checksum byte -> load_error=1, load_done=0, core_reset=1.
